// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer in front of a word-addressed data memory.
// Handles byte/halfword lane selection with extension, SB/SH read-modify-write, and misalign/range errors.
module load_store_unit #(
  parameter int MEM_WORDS  = 51,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and req_* are ignored once transferred.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] address,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] writeData,
  input  logic [31:0] readData,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        st_done,
  output logic        misalign,
  output logic        addr_err,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, RMW_RD, RMW_MRG, RMW_WR} state_t;

  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3,
                         OP_LHU = 3'd4, OP_SB = 3'd5, OP_SH = 3'd6, OP_SW = 3'd7;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state, stateNext;
  logic [2:0]  opReg, opNext;
  logic [1:0]  offReg, offNext;
  logic [15:0] wdReg, wdNext;
  logic [31:0] addressNext, writeDataNext, ldDataNext;
  logic        memReadNext, memWriteNext, ldValidNext, stDoneNext, misalignNext, addrErrNext;

  logic        transfer, isMisaligned, outOfRange;
  logic [1:0]  byteSel;
  logic        halfSel;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] loadExt, merged;

  assign req_ready = (state == IDLE);
  assign dbgState  = state;
  assign transfer  = req_valid && req_ready;
  assign outOfRange = {2'b00, req_addr[31:2]} >= MEM_LIMIT;

  always_comb begin
    isMisaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:          isMisaligned = |req_addr[1:0];
      OP_LH, OP_LHU, OP_SH:  isMisaligned = req_addr[0];
      default:               isMisaligned = 1'b0;
    endcase
  end

  // Big-endian puts byte offset 0 in the top lane, so the lane index is the inverted offset.
  assign byteSel = BIG_ENDIAN ? ~offReg : offReg;
  assign halfSel = BIG_ENDIAN ? ~offReg[1] : offReg[1];
  assign byteVal = readData[{byteSel, 3'b000} +: 8];
  assign halfVal = readData[{halfSel, 4'b0000} +: 16];

  always_comb begin
    loadExt = readData;
    case (opReg)
      OP_LB:   loadExt = {{24{byteVal[7]}}, byteVal};
      OP_LH:   loadExt = {{16{halfVal[15]}}, halfVal};
      OP_LBU:  loadExt = {24'd0, byteVal};
      OP_LHU:  loadExt = {16'd0, halfVal};
      default: loadExt = readData;
    endcase
  end

  always_comb begin
    merged = readData;
    if (opReg == OP_SB) merged[{byteSel, 3'b000} +: 8] = wdReg[7:0];
    else                merged[{halfSel, 4'b0000} +: 16] = wdReg;
  end

  always_comb begin
    stateNext     = state;
    opNext        = opReg;
    offNext       = offReg;
    wdNext        = wdReg;
    addressNext   = address;
    writeDataNext = writeData;
    ldDataNext    = ld_data;
    memReadNext   = 1'b0;
    memWriteNext  = 1'b0;
    ldValidNext   = 1'b0;
    stDoneNext    = 1'b0;
    misalignNext  = 1'b0;
    addrErrNext   = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (isMisaligned)    misalignNext = 1'b1;
          else if (outOfRange) addrErrNext  = 1'b1;
          else begin
            opNext      = req_op;
            offNext     = req_addr[1:0];
            wdNext      = req_wdata[15:0];
            addressNext = {2'b00, req_addr[31:2]};
            case (req_op)
              OP_SW: begin
                stateNext     = WR;
                memWriteNext  = 1'b1;
                writeDataNext = req_wdata;
              end
              OP_SB, OP_SH: begin
                stateNext   = RMW_RD;
                memReadNext = 1'b1;
              end
              default: begin
                stateNext   = RD;
                memReadNext = 1'b1;
              end
            endcase
          end
        end
      end
      RD:     stateNext = RD_CAP;
      RD_CAP: begin
        ldDataNext  = loadExt;
        ldValidNext = 1'b1;
        stateNext   = IDLE;
      end
      WR: begin
        stDoneNext = 1'b1;
        stateNext  = IDLE;
      end
      RMW_RD: stateNext = RMW_MRG;
      // writeData only ever takes the complete merged word, never a partial one.
      RMW_MRG: begin
        writeDataNext = merged;
        memWriteNext  = 1'b1;
        stateNext     = RMW_WR;
      end
      RMW_WR: begin
        stDoneNext = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      opReg     <= 3'd0;
      offReg    <= 2'd0;
      wdReg     <= 16'd0;
      address   <= 32'd0;
      writeData <= 32'd0;
      ld_data   <= 32'd0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      ld_valid  <= 1'b0;
      st_done   <= 1'b0;
      misalign  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state     <= stateNext;
      opReg     <= opNext;
      offReg    <= offNext;
      wdReg     <= wdNext;
      address   <= addressNext;
      writeData <= writeDataNext;
      ld_data   <= ldDataNext;
      memRead   <= memReadNext;
      memWrite  <= memWriteNext;
      ld_valid  <= ldValidNext;
      st_done   <= stDoneNext;
      misalign  <= misalignNext;
      addr_err  <= addrErrNext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read 51-word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] address;
  logic        memRead;
  logic        memWrite;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        st_done;
  logic        misalign;
  logic        addr_err;
  logic [2:0]  dbgState;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem[0:50];
  logic [31:0] rdReg = 32'd0;
  logic        memLoad;
  int          wrCount = 0;
  int          wrBefore;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  load_store_unit #(.MEM_WORDS(51), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .address(address), .memRead(memRead), .memWrite(memWrite),
    .writeData(writeData), .readData(readData),
    .ld_valid(ld_valid), .ld_data(ld_data), .st_done(st_done),
    .misalign(misalign), .addr_err(addr_err), .dbgState(dbgState)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: synchronous read, write on strobe
  always @(posedge clk) begin
    if (memLoad) begin
      for (int i = 0; i < 51; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[2] <= 32'h8123_4567;
    end else begin
      if (memRead && address < 51) rdReg <= mem[address[5:0]];
      if (memWrite) begin
        wrCount <= wrCount + 1;
        if (address < 51) mem[address[5:0]] <= writeData;
      end
    end
  end
  assign readData = rdReg;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Driver: waits (bounded) for req_ready, transfers one request, returns one cycle after transfer.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (!req_ready && n < 20) begin
      step;
      n++;
    end
    check("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    step;
    req_valid = 1'b0;
    req_op    = $urandom_range(7, 0);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic doLoad(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(op, addr, 32'd0);
    check({tag, "_rd_strobe"}, {31'd0, memRead}, 32'd1);
    check({tag, "_rd_nowrite"}, {31'd0, memWrite}, 32'd0);
    check({tag, "_rd_address"}, address, {2'b00, addr[31:2]});
    step;
    check({tag, "_cap_strobe"}, {31'd0, memRead}, 32'd0);
    check({tag, "_cap_no_valid"}, {31'd0, ld_valid}, 32'd0);
    step;
    check({tag, "_ld_valid"}, {31'd0, ld_valid}, 32'd1);
    if (exp_q.size() > 0) check({tag, "_ld_data"}, ld_data, exp_q.pop_front());
    step;
    check({tag, "_ld_valid_drop"}, {31'd0, ld_valid}, 32'd0);
  endtask

  task automatic doSubStore(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] expWord);
    issue(op, addr, wdata);
    check({tag, "_rmw_rd"}, {31'd0, memRead}, 32'd1);
    check({tag, "_rmw_address"}, address, {2'b00, addr[31:2]});
    step;
    check({tag, "_mrg_strobes"}, {30'd0, memRead, memWrite}, 32'd0);
    step;
    check({tag, "_wr_strobes"}, {30'd0, memRead, memWrite}, 32'd1);
    check({tag, "_wr_data"}, writeData, expWord);
    check({tag, "_wr_address"}, address, {2'b00, addr[31:2]});
    step;
    check({tag, "_st_done"}, {31'd0, st_done}, 32'd1);
    check({tag, "_wr_drop"}, {31'd0, memWrite}, 32'd0);
  endtask

  task automatic doErr(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic expMis, input logic expErr);
    issue(op, addr, 32'hDEAD_BEEF);
    check({tag, "_flags"}, {30'd0, misalign, addr_err}, {30'd0, expMis, expErr});
    check({tag, "_no_strobe"}, {30'd0, memRead, memWrite}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    step;
    check({tag, "_flags_drop"}, {30'd0, misalign, addr_err}, 32'd0);
    check({tag, "_still_no_strobe"}, {30'd0, memRead, memWrite}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    memLoad   = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    step;
    step;
    check("rst_address", address, 32'd0);
    check("rst_writeData", writeData, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_pulses", {26'd0, memRead, memWrite, ld_valid, st_done, misalign, addr_err}, 32'd0);
    check("rst_state", {29'd0, dbgState}, 32'd0);
    memLoad = 1'b0;
    reset   = 1'b0;
    step;

    // Loads on word 2 = 0x8123_4567
    doLoad("lw_8",   LW,  32'h8, 32'h8123_4567);
    doLoad("lb_9",   LB,  32'h9, 32'h0000_0023);
    doLoad("lbu_9",  LBU, 32'h9, 32'h0000_0023);
    doLoad("lb_8",   LB,  32'h8, 32'hFFFF_FF81);
    doLoad("lbu_8",  LBU, 32'h8, 32'h0000_0081);
    doLoad("lh_a",   LH,  32'hA, 32'h0000_4567);
    doLoad("lh_8",   LH,  32'h8, 32'hFFFF_8123);
    doLoad("lhu_8",  LHU, 32'h8, 32'h0000_8123);
    doLoad("lw_c8",  LW,  32'hC8, 32'h1000_0032);

    // Sub-word stores then read back
    doSubStore("sh_a", SH, 32'hA, 32'h1234_BEEF, 32'h8123_BEEF);
    doLoad("lw_8_after_sh", LW, 32'h8, 32'h8123_BEEF);
    doSubStore("sb_5", SB, 32'h5, 32'h0000_00AA, 32'h10AA_0001);
    doLoad("lw_4_after_sb", LW, 32'h4, 32'h10AA_0001);

    // Error paths
    doErr("lw_6_mis",   LW, 32'h6,  1'b1, 1'b0);
    doErr("lw_cc_oor",  LW, 32'hCC, 1'b0, 1'b1);
    doErr("lh_cd_both", LH, 32'hCD, 1'b1, 1'b0);
    doErr("sw_ce_mis",  SW, 32'hCE, 1'b1, 1'b0);

    // Reset during RMW_MRG must abort without a write
    wrBefore = wrCount;
    issue(SB, 32'hC, 32'h0000_0055);
    check("abort_rmw_rd", {31'd0, memRead}, 32'd1);
    step;
    check("abort_in_mrg", {29'd0, dbgState}, 32'd5);
    reset = 1'b1;
    #1;
    check("abort_outputs", {26'd0, memRead, memWrite, ld_valid, st_done, misalign, addr_err}, 32'd0);
    check("abort_state", {29'd0, dbgState}, 32'd0);
    check("abort_writeData", writeData, 32'd0);
    step;
    step;
    reset = 1'b0;
    step;
    step;
    check("abort_no_write", 32'(wrCount), 32'(wrBefore));
    check("abort_no_st_done", {31'd0, st_done}, 32'd0);
    doLoad("lw_c_after_abort", LW, 32'hC, 32'h1000_0003);

    // Back-to-back SW then LW with req_valid held
    req_valid = 1'b1;
    req_op    = SW;
    req_addr  = 32'h0;
    req_wdata = 32'h1111_1111;
    check("b2b_ready_first", {31'd0, req_ready}, 32'd1);
    step;
    req_op    = LW;
    req_wdata = 32'h0;
    check("b2b_wr_strobe", {30'd0, memRead, memWrite}, 32'd1);
    check("b2b_wr_data", writeData, 32'h1111_1111);
    check("b2b_busy", {31'd0, req_ready}, 32'd0);
    step;
    check("b2b_st_done", {31'd0, st_done}, 32'd1);
    check("b2b_gap", {30'd0, memRead, memWrite}, 32'd0);
    check("b2b_ready_back", {31'd0, req_ready}, 32'd1);
    step;
    req_valid = 1'b0;
    check("b2b_rd_strobe", {30'd0, memRead, memWrite}, 32'd2);
    check("b2b_rd_address", address, 32'd0);
    step;
    step;
    check("b2b_ld_valid", {31'd0, ld_valid}, 32'd1);
    check("b2b_ld_data", ld_data, 32'h1111_1111);
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage sequencer sitting directly upstream of the word-addressed data memory. It takes byte-addressed load/store requests from the MIPS pipeline and drives the memory's address, memRead, memWrite and writeData inputs. It consumes the memory's readData.
- Performs byte/halfword extraction with sign/zero extension on loads, and read-modify-write for SB/SH.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 51, number of 32-bit words in data memory; valid word indices are 0..MEM_WORDS-1.
- BIG_ENDIAN, 1, 1: byte offset 0 is bits [31:24] (MIPS); 0: byte offset 0 is bits [7:0].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high when the unit can accept a request (state IDLE).
- req_op  input  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; SB uses [7:0], SH uses [15:0].
- address  output  32  word index to memory, equal to req_addr[31:2] zero-extended.
- memRead  output  1  memory read strobe.
- memWrite  output  1  memory write strobe.
- writeData  output  32  word written to memory.
- readData  input  32  word returned by memory.
- ld_valid  output  1  one-cycle pulse; ld_data is valid.
- ld_data  output  32  extended load result.
- st_done  output  1  one-cycle pulse when a store's memory write completes.
- misalign  output  1  one-cycle pulse on a misaligned request.
- addr_err  output  1  one-cycle pulse when the word index is >= MEM_WORDS.

Behaviour:
- Handshake: a request transfers when req_valid && req_ready. Requests are sampled only in IDLE. req_* are don't-care after transfer.
- Reset (asynchronous):
  - state = IDLE; req_ready = 1.
  - address, writeData, ld_data = 0.
  - memRead, memWrite, ld_valid, st_done, misalign, addr_err = 0.
- All outputs except req_ready are registered. req_ready = (state == IDLE).
- Request checks, evaluated in the transfer cycle:
  - Misaligned: LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] != 0. Result: misalign pulses next cycle, no memory strobe, state stays IDLE.
  - Out of range: word index >= MEM_WORDS and aligned. Result: addr_err pulses next cycle, no strobe, stays IDLE.
  - Misalign takes priority over addr_err; only one flag pulses.
- States: IDLE, RD, RD_CAP, WR, RMW_RD, RMW_MRG, RMW_WR.
- Loads (LB/LH/LW/LBU/LHU): IDLE -> RD -> RD_CAP -> IDLE.
  - In RD: memRead = 1, address = index.
  - In RD_CAP: capture readData and select lane by addr[1:0] per BIG_ENDIAN. LB/LH sign-extend; LBU/LHU zero-extend.
  - ld_valid pulses the cycle after RD_CAP, i.e. 3 cycles after transfer.
- SW: IDLE -> WR -> IDLE.
  - In WR: memWrite = 1, writeData = req_wdata.
  - st_done pulses the cycle after WR.
- SB/SH: IDLE -> RMW_RD -> RMW_MRG -> RMW_WR -> IDLE.
  - RMW_RD: memRead = 1.
  - RMW_MRG: capture readData and replace the selected lane(s) with the store data.
  - RMW_WR: memWrite = 1, writeData = merged word.
  - st_done pulses the cycle after RMW_WR.
- Strobe rules:
  - memRead and memWrite are never both high.
  - Each strobe is high for exactly one cycle per access; both are low in IDLE, RD_CAP and RMW_MRG.
  - address is held constant from the first strobe cycle through the end of the operation.
- Back-to-back: a new request may transfer in the cycle the unit returns to IDLE. Its first strobe can follow a previous strobe with one idle cycle between.
- Reset mid-operation: strobes drop immediately; no pulse is issued for the aborted operation.
  - A reset during RMW_MRG or RMW_WR means the memory word is not written, or is written at most with the fully merged value.
- No state ever issues a write with a partially merged word.

Test Plan:
- Reset, then LW addr 0x8 with memory word 2 = 0x8123_4567 -> RD strobe address=2; ld_valid 3 cycles after transfer with ld_data = 0x8123_4567.
- LB addr 0x9 and LBU addr 0x9 on the same word, BIG_ENDIAN=1 -> ld_data = 0x0000_0023 for both. LB addr 0x8 -> 0xFFFF_FF81; LBU addr 0x8 -> 0x0000_0081.
- SH addr 0xA, wdata 0xXXXX_BEEF, word 2 = 0x8123_4567 -> memWrite with writeData = 0x8123_BEEF; st_done pulses; a following LW addr 0x8 returns 0x8123_BEEF.
- LW addr 0x6 -> misalign pulse, no memRead or memWrite. LW addr 51*4 = 0xCC -> addr_err pulse, no strobe, req_ready stays 1.
- SB issued, reset asserted during RMW_MRG -> memWrite never rises, all outputs 0 asynchronously, state IDLE; word unchanged when read back.
- Back-to-back SW addr 0x0 (0x1111_1111) then LW addr 0x0 with req_valid held -> second transfer the cycle req_ready returns; ld_data = 0x1111_1111.
